// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// pipe_pkg : state encodings shared by the pipeline skid register and control
// Rev 1.0
// ============================================================================
package pipe_pkg;
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;
endpackage
`default_nettype wire

// File: rtl/pipe_data_reg.sv
`default_nettype none
// ============================================================================
// pipe_data_reg : n-bit data register, synchronous active-low reset, load enable
// Rev 1.0
// ============================================================================
module pipe_data_reg #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [n-1:0] i_d,
  output logic [n-1:0] o_q
);
  logic [n-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;
endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// pipe_skid_reg : 2-entry skid buffer between pipeline stages, valid/ready
// Rev 1.0
// ============================================================================
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] di,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] dout
);
  logic [1:0]   r_state;
  logic         w_accept;
  logic         w_consume;
  logic         w_main_load;
  logic         w_skid_load;
  logic [n-1:0] w_main_d;
  logic [n-1:0] w_main_q;
  logic [n-1:0] w_skid_q;

  // Handshake flags come from registered state only, so out_ready never reaches in_ready.
  assign in_ready  = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_consume = out_valid & out_ready;

  always_comb begin
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_main_d    = di;
    if (!flush) begin
      case (r_state)
        ST_EMPTY: w_main_load = w_accept;
        ST_BUSY: begin
          w_main_load = w_accept & w_consume;
          w_skid_load = w_accept & ~w_consume;
        end
        ST_FULL: begin
          w_main_load = w_consume;
          w_main_d    = w_skid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_accept) r_state <= ST_BUSY;
        ST_BUSY: begin
          if (w_accept && !w_consume) r_state <= ST_FULL;
          else if (!w_accept && w_consume) r_state <= ST_EMPTY;
        end
        ST_FULL: if (w_consume) r_state <= ST_BUSY;
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  pipe_data_reg #(.n(n)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_main_load),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  pipe_data_reg #(.n(n)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_skid_load),
    .i_d   (di),
    .o_q   (w_skid_q)
  );

  assign dout = w_main_q;
endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// tb_pipe_skid_reg : randomized + directed bench against a queue-based model
// Rev 1.0
// ============================================================================
module tb_pipe_skid_reg;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] di = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;

  logic [31:0] mq[$];
  bit          zero_do = 1'b1;
  bit          cmp_en  = 1'b0;

  pipe_skid_reg #(.n(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .di       (di),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model: the buffer is a FIFO of at most two words; do shows the oldest.
  task automatic model_step();
    bit cons, acc;
    if (!rst_n) begin
      mq.delete();
      zero_do = 1'b1;
    end else if (flush) begin
      mq.delete();
    end else begin
      cons = (mq.size() > 0) && out_ready;
      acc  = in_valid && (mq.size() < 2);
      if (cons) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(di);
        zero_do = 1'b0;
      end
    end
  endtask

  task automatic compare();
    if (!cmp_en) return;
    chk("model out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    chk("model in_ready", {31'd0, in_ready}, {31'd0, mq.size() < 2});
    if (mq.size() > 0) chk("model do", dout, mq[0]);
    else if (zero_do) chk("model do after reset", dout, 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit rdy);
    in_valid  = v;
    di        = d;
    out_ready = rdy;
  endtask

  initial begin
    logic [31:0] cnt;
    // Reset with a live offer on the input
    drive(1'b1, 32'hDEADBEEF, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    rst_n  = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset do", dout, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);

    // Streaming
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, i, 1'b1);
      tick();
      chk("stream do", dout, i);
      chk("stream out_valid", {31'd0, out_valid}, 32'd1);
      chk("stream in_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("stream drained", {31'd0, out_valid}, 32'd0);

    // Backpressure
    drive(1'b1, 32'hA, 1'b0);
    tick();
    drive(1'b1, 32'hB, 1'b0);
    tick();
    chk("bp in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp do", dout, 32'hA);
    drive(1'b1, 32'hC, 1'b0);
    tick();
    chk("bp do stable", dout, 32'hA);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("bp do second", dout, 32'hB);
    chk("bp in_ready back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp empty", {31'd0, out_valid}, 32'd0);

    // Flush while full, with a simultaneous offer
    drive(1'b1, 32'h10, 1'b0);
    tick();
    drive(1'b1, 32'h11, 1'b0);
    tick();
    chk("pre-flush in_ready", {31'd0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h12, 1'b0);
    tick();
    flush = 1'b0;
    chk("flush out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush in_ready", {31'd0, in_ready}, 32'd1);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("flush word dropped", {31'd0, out_valid}, 32'd0);

    // Random traffic
    cnt = 32'h100;
    for (int i = 0; i < 100; i++) begin
      drive(1'($urandom_range(0, 3) != 0), cnt, 1'($urandom_range(0, 3) != 0));
      cnt++;
      tick();
    end
    drive(1'b0, 32'h0, 1'b1);
    tick();
    tick();
    chk("random drained", {31'd0, out_valid}, 32'd0);

    // Reset while full
    drive(1'b1, 32'h20, 1'b0);
    tick();
    drive(1'b1, 32'h21, 1'b0);
    tick();
    chk("pre-reset full", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    drive(1'b1, 32'h99, 1'b1);
    tick();
    rst_n = 1'b1;
    chk("mid reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid reset do", dout, 32'd0);
    drive(1'b1, 32'h55, 1'b0);
    tick();
    chk("post reset first word", dout, 32'h55);
    drive(1'b0, 32'h0, 1'b1);
    tick();
    chk("post reset only word", {31'd0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
